// File: rtl/pipe_stage_reg_if.sv
// Valid/ready/data bundle for one side of a pipeline stage boundary.
// master drives valid and data; slave drives ready.
interface pipe_stage_reg_if #(
  parameter int W = 160
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush and a saturating stall-cycle counter.
// Latency 1 cycle; in_ready drops when full (PIPE_STAGE_REG_SKID_EN: 2-entry skid, in_ready from a flop).
// Backpressure: out_data/out_valid hold while stalled; in_ready forced low during reset.
module pipe_stage_reg #(
  parameter int                   PAYLOAD_W = 160,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0,
  parameter int                   CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  pipe_stage_reg_if.slave       in_if,
  pipe_stage_reg_if.master      out_if,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                 acc;
  logic                 emit;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [CNT_W-1:0]     stall_q, stall_d;

  // A beat offered while flushing is squashed even if in_ready is high.
  assign acc          = in_if.valid && in_if.ready && !flush;
  assign emit         = out_if.valid && out_if.ready;
  assign out_if.data  = main_q;
  assign stall_cycles = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (out_if.valid && !out_if.ready && (stall_q != '1)) begin
      stall_d = stall_q + CNT_ONE;
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;

  assign out_if.valid = (state_q != ST_EMPTY);
  assign in_if.ready  = in_ready_q && !reset;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_d  = in_if.data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && emit) begin
          main_d = in_if.data;
        end else if (acc) begin
          skid_d  = in_if.data;
          state_d = ST_TWO;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush leaves out_data as it was, even if a skid promotion was pending.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= RESET_VAL;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end
`else
  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  state_t state_q, state_d;

  assign out_if.valid = (state_q != ST_EMPTY);
  assign in_if.ready  = (!out_if.valid || out_if.ready) && !reset;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (acc) begin
      main_d  = in_if.data;
      state_d = ST_FULL;
    end else if (emit) begin
      state_d = ST_EMPTY;
    end
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      stall_q <= stall_d;
    end
  end
`endif

endmodule
